uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// Serial UART transmit framer. Sends start bit, DATA_WIDTH data bits LSB first,
// an optional even/odd parity bit and a stop bit, one bit per clk cycle.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_q;
    logic                    par_bit;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    // STOP shares the acceptance path so frames can run back-to-back
                    if (data_valid) begin
                        shreg    <= p_data;
                        par_en_q <= par_en;
                        par_bit  <= parity_of(p_data, par_typ);
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end else begin
                        tx_out   <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                START: begin
                    tx_out <= shreg[0];
                    shreg  <= shreg >> 1;
                    cnt    <= '0;
                    state  <= DATA;
                end
                DATA: begin
                    if (cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            tx_out <= par_bit;
                            state  <= PARITY;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end
                    end else begin
                        tx_out <= shreg[0];
                        shreg  <= shreg >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    tx_out <= 1'b1;
                    state  <= STOP;
                end
                default: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
